// File: rtl/rv_imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
// DEPTH and the timeout default describe the standard 64 Kword build.
package rv_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam int DEFAULT_IMEM_SIZE = 64;
  localparam int DEPTH             = DEFAULT_IMEM_SIZE * 1024;
  localparam int DEFAULT_TIMEOUT   = 1000000;

  // Depth in words at the 17-bit width used for the word-count check
  function automatic logic [16:0] depth17(input int imem_size);
    return 17'(imem_size * 1024);
  endfunction

endpackage

// File: rtl/rv_imem_loader_if.sv
// Host-link, instruction-memory write and status signals of the loader.
// The slave side is the loader; the master side is the host/memory side.
interface rv_imem_loader_if;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        instr_wr_en;
  logic [31:0] instr_in;
  logic [15:0] addr;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  modport slave (
    input  load_start, byte_valid, byte_data,
    output byte_ready, instr_wr_en, instr_in, addr, core_hold, done, error, words_loaded
  );

  modport master (
    output load_start, byte_valid, byte_data,
    input  byte_ready, instr_wr_en, instr_in, addr, core_hold, done, error, words_loaded
  );
endinterface

// File: rtl/rv_imem_loader_packer.sv
// Little-endian byte-to-word assembler. The word is presented combinationally
// with the 4th byte in place, so the loader can register it on that same edge.
module rv_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_vld
);

  logic [1:0]      r_idx;
  logic [2:0][7:0] r_bytes;

  assign o_word     = {i_byte, r_bytes[2], r_bytes[1], r_bytes[0]};
  assign o_word_vld = i_accept && (r_idx == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= 2'd0;
      r_bytes <= '0;
    end else if (i_clr) begin
      r_idx <= 2'd0;
    end else if (i_accept) begin
      r_idx <= r_idx + 2'd1;
      case (r_idx)
        2'd0:    r_bytes[0] <= i_byte;
        2'd1:    r_bytes[1] <= i_byte;
        2'd2:    r_bytes[2] <= i_byte;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rv_imem_loader.sv
// Loads a count-prefixed little-endian word stream into instruction memory
// at consecutive addresses from 0, holding the core in reset meanwhile.
module rv_imem_loader
  import rv_loader_pkg::*;
#(
  parameter int IMEM_SIZE      = DEFAULT_IMEM_SIZE,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  rv_imem_loader_if.slave bus
);

  localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0]       L_DEPTH    = depth17(IMEM_SIZE);
  localparam logic [IDLE_W-1:0] L_IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES - 1);

  loader_state_t     r_state;
  logic [15:0]       r_count;
  logic [16:0]       r_wcnt;
  logic [IDLE_W-1:0] r_idle;
  logic              r_byte_ready;
  logic              r_instr_wr_en;
  logic [31:0]       r_instr_in;
  logic [15:0]       r_addr;
  logic              r_core_hold;
  logic              r_done;
  logic              r_error;
  logic [15:0]       r_words_loaded;

  logic        w_accept;
  logic        w_in_rx;
  logic        w_timeout;
  logic        w_start;
  logic [15:0] w_cnt;
  logic [31:0] w_word;
  logic        w_word_vld;

  assign w_accept  = bus.byte_valid && r_byte_ready;
  assign w_in_rx   = (r_state == CNT_LO) || (r_state == CNT_HI) || (r_state == DATA);
  assign w_timeout = w_in_rx && !w_accept && (r_idle == L_IDLE_MAX);
  assign w_start   = bus.load_start &&
                     ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_cnt     = {bus.byte_data, r_count[7:0]};

  rv_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      ((r_state != DATA) && (r_state != WRITE)),
    .i_accept   (w_accept && (r_state == DATA)),
    .i_byte     (bus.byte_data),
    .o_word     (w_word),
    .o_word_vld (w_word_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_wcnt         <= '0;
      r_idle         <= '0;
      r_byte_ready   <= 1'b0;
      r_instr_wr_en  <= 1'b0;
      r_instr_in     <= '0;
      r_addr         <= '0;
      r_core_hold    <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= '0;
    end else begin
      r_instr_wr_en <= 1'b0;
      r_done        <= 1'b0;

      if (w_start) begin
        r_state        <= CNT_LO;
        r_core_hold    <= 1'b1;
        r_error        <= 1'b0;
        r_words_loaded <= '0;
        r_wcnt         <= '0;
        r_idle         <= '0;
        r_byte_ready   <= 1'b1;
      end else if (w_timeout) begin
        // Any partial word is dropped; already-written words stay in memory
        r_state      <= ERR;
        r_error      <= 1'b1;
        r_byte_ready <= 1'b0;
      end else begin
        if (w_in_rx)
          r_idle <= w_accept ? '0 : r_idle + 1'b1;

        case (r_state)
          CNT_LO: if (w_accept) begin
            r_count[7:0] <= bus.byte_data;
            r_state      <= CNT_HI;
          end
          CNT_HI: if (w_accept) begin
            r_count <= w_cnt;
            if (w_cnt == 16'd0) begin
              r_state      <= DONE;
              r_done       <= 1'b1;
              r_core_hold  <= 1'b0;
              r_byte_ready <= 1'b0;
            end else if ({1'b0, w_cnt} > L_DEPTH) begin
              r_state      <= ERR;
              r_error      <= 1'b1;
              r_byte_ready <= 1'b0;
            end else begin
              r_state <= DATA;
            end
          end
          DATA: if (w_word_vld) begin
            r_state       <= WRITE;
            r_instr_wr_en <= 1'b1;
            r_instr_in    <= w_word;
            r_addr        <= r_wcnt[15:0];
            r_byte_ready  <= 1'b0;
          end
          WRITE: begin
            r_wcnt         <= r_wcnt + 17'd1;
            r_words_loaded <= r_words_loaded + 16'd1;
            if (r_wcnt + 17'd1 == {1'b0, r_count}) begin
              r_state     <= DONE;
              r_done      <= 1'b1;
              r_core_hold <= 1'b0;
            end else begin
              r_state      <= DATA;
              r_byte_ready <= 1'b1;
              r_idle       <= '0;
            end
          end
          DONE:    r_state <= IDLE;
          default: ;
        endcase
      end
    end
  end

  assign bus.byte_ready   = r_byte_ready;
  assign bus.instr_wr_en  = r_instr_wr_en;
  assign bus.instr_in     = r_instr_in;
  assign bus.addr         = r_addr;
  assign bus.core_hold    = r_core_hold;
  assign bus.done         = r_done;
  assign bus.error        = r_error;
  assign bus.words_loaded = r_words_loaded;

endmodule

// File: tb/tb_rv_imem_loader.sv
// Directed bench for rv_imem_loader: basic load, zero count, oversize,
// timeout, count at full depth, backpressure and asynchronous reset.
module tb_rv_imem_loader;

  logic clk;
  logic rst;
  rv_imem_loader_if bus();

  rv_imem_loader #(.IMEM_SIZE(1), .TIMEOUT_CYCLES(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [15:0] wa_q[$];
  logic [31:0] wd_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.instr_wr_en) begin
      wa_q.push_back(bus.addr);
      wd_q.push_back(bus.instr_in);
    end
    if (bus.done) done_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load;
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic put(input logic [7:0] b);
    int k = 0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (!bus.byte_ready && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_wait: byte %0h observed no ready expected ready within 50 cycles", b);
    end
    tick();
  endtask

  task automatic put_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) put(w[8*i +: 8]);
  endtask

  initial begin
    int base;
    logic [31:0] words [3];
    words[0] = 32'h11223344;
    words[1] = 32'hA5A50F0F;
    words[2] = 32'hCAFEF00D;

    rst = 1'b1;
    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    #1;
    check("rst_ready",   bus.byte_ready,   0);
    check("rst_wr_en",   bus.instr_wr_en,  0);
    check("rst_instr",   bus.instr_in,     0);
    check("rst_addr",    bus.addr,         0);
    check("rst_hold",    bus.core_hold,    0);
    check("rst_done",    bus.done,         0);
    check("rst_error",   bus.error,        0);
    check("rst_words",   bus.words_loaded, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("idle_ready", bus.byte_ready, 0);

    // Basic load: two words, byte_valid held throughout
    start_load();
    check("basic_hold_on", bus.core_hold, 1);
    check("basic_ready",   bus.byte_ready, 1);
    put(8'h02); put(8'h00);
    put_word(32'h00000013);
    check("basic_wr0_en",   bus.instr_wr_en, 1);
    check("basic_wr0_addr", bus.addr, 0);
    check("basic_wr0_data", bus.instr_in, 32'h00000013);
    check("basic_wr_ready", bus.byte_ready, 0);
    put(8'h93);
    check("basic_wr0_off", bus.instr_wr_en, 0);
    put(8'h00); put(8'h10); put(8'h00);
    bus.byte_valid = 1'b0;
    check("basic_wr1_en",   bus.instr_wr_en, 1);
    check("basic_wr1_addr", bus.addr, 1);
    check("basic_wr1_data", bus.instr_in, 32'h00100093);
    tick();
    check("basic_done",     bus.done, 1);
    check("basic_hold_off", bus.core_hold, 0);
    check("basic_words",    bus.words_loaded, 2);
    tick();
    check("basic_done_pulse", bus.done, 0);
    check("basic_nwrites",    wa_q.size(), 2);
    check("basic_ndone",      done_cnt, 1);
    check("basic_mem0",       wd_q[0], 32'h00000013);
    check("basic_mem1",       wd_q[1], 32'h00100093);

    // Zero count
    start_load();
    put(8'h00); put(8'h00);
    bus.byte_valid = 1'b0;
    check("zero_done",  bus.done, 1);
    check("zero_error", bus.error, 0);
    check("zero_words", bus.words_loaded, 0);
    tick();
    check("zero_nwrites", wa_q.size(), 2);
    check("zero_ndone",   done_cnt, 2);

    // Oversize: 0x0401 words into a 1024-word memory
    start_load();
    put(8'h01); put(8'h04);
    bus.byte_valid = 1'b0;
    check("over_error", bus.error, 1);
    check("over_hold",  bus.core_hold, 1);
    check("over_ready", bus.byte_ready, 0);
    tick(); tick(); tick();
    check("over_sticky", bus.error, 1);

    // Restart from ERR, then timeout after two data bytes
    start_load();
    check("restart_error", bus.error, 0);
    check("restart_hold",  bus.core_hold, 1);
    put(8'h01); put(8'h00);
    put(8'hAA); put(8'hBB);
    bus.byte_valid = 1'b0;
    repeat (19) tick();
    check("tmo_early", bus.error, 0);
    tick();
    check("tmo_error",   bus.error, 1);
    check("tmo_ready",   bus.byte_ready, 0);
    check("tmo_nwrites", wa_q.size(), 2);

    // Count exactly equal to depth is accepted
    start_load();
    put(8'h00); put(8'h04);
    check("depth_error", bus.error, 0);
    check("depth_ready", bus.byte_ready, 1);
    put(8'h11); put(8'h22);
    bus.byte_valid = 1'b0;

    // Asynchronous reset mid-DATA, between clock edges
    #3 rst = 1'b1;
    #1;
    check("arst_hold",  bus.core_hold, 0);
    check("arst_ready", bus.byte_ready, 0);
    check("arst_instr", bus.instr_in, 0);
    check("arst_error", bus.error, 0);
    #2 rst = 1'b0;
    tick();
    base = wa_q.size();
    start_load();
    put(8'h01); put(8'h00);
    put_word(32'hDEADBEEF);
    bus.byte_valid = 1'b0;
    check("arst_wr_addr", bus.addr, 0);
    check("arst_wr_data", bus.instr_in, 32'hDEADBEEF);
    tick();
    check("arst_done",  bus.done, 1);
    check("arst_words", bus.words_loaded, 1);
    check("arst_nwrites", wa_q.size(), base + 1);

    // Backpressure with random gaps and a byte presented during WRITE
    tick();
    base = wa_q.size();
    start_load();
    put(8'h03); put(8'h00);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) begin
        if (w > 0 && i == 0) begin
          bus.byte_valid = 1'b1;
          bus.byte_data  = words[w][7:0];
          check("bp_ready_in_write", bus.byte_ready, 0);
        end else begin
          int gap = $urandom_range(0, 3);
          bus.byte_valid = 1'b0;
          repeat (gap) tick();
        end
        put(words[w][8*i +: 8]);
      end
    end
    bus.byte_valid = 1'b0;
    tick();
    check("bp_done",    bus.done, 1);
    check("bp_words",   bus.words_loaded, 3);
    check("bp_nwrites", wa_q.size(), base + 3);
    for (int w = 0; w < 3; w++) begin
      if (wa_q.size() > base + w) begin
        check("bp_addr", wa_q[base + w], w);
        check("bp_data", wd_q[base + w], words[w]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
